// File: rtl/fib_pkg.sv
// Shared types and helpers for the Fibonacci stream checker.
package fib_pkg;

  localparam int FIB_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEED  = 2'd1,
    ST_CHECK = 2'd2,
    ST_FAIL  = 2'd3
  } fib_state_e;

  // (x + y) mod 2^w; callers cast the result down to their lane width.
  function automatic logic [63:0] fib_next(input logic [63:0] x,
                                           input logic [63:0] y,
                                           input int unsigned w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (x + y) & mask;
  endfunction

endpackage

// File: rtl/fib_expect.sv
// Combinational lookahead: the next two Fibonacci terms after reference pair (a, b).
module fib_expect
  import fib_pkg::*;
#(
  parameter int W = FIB_W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] e1,
  output logic [W-1:0] e2
);

  always_comb begin
    e1 = W'(fib_next(64'(a), 64'(b), W));
    e2 = W'(fib_next(64'(b), 64'(e1), W));
  end

endmodule

// File: rtl/fibonacci_checker.sv
// Checks that an accepted number stream obeys x[n] = x[n-1] + x[n-2] mod 2^W.
// Define FIB_CHECK_DOUBLE_RATE_EN to check two numbers (num, num2) per vld beat.
module fibonacci_checker
  import fib_pkg::*;
#(
  parameter int W  = FIB_W_DEFAULT,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          vld,
  input  logic [W-1:0]  num,
  input  logic [W-1:0]  num2,
  output logic          locked,
  output logic          err,
  output logic          fail,
  output logic [CW-1:0] err_cnt,
  output logic [15:0]   chk_cnt,
  output logic [1:0]    dbg_state
);

  // Handshake: a beat is accepted on every rising edge where vld=1; there is no
  // ready, the checker always consumes. clr has priority over vld.

  fib_state_e    state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic          fail_q, fail_d;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [15:0]   chk_cnt_q, chk_cnt_d;

  logic [W-1:0]  e1, e2;
  logic          cmp;
  logic [1:0]    n_mis;
  logic [1:0]    n_chk;
  logic [CW:0]   ec_sum;

  fib_expect #(.W(W)) u_expect (
    .a  (a_q),
    .b  (b_q),
    .e1 (e1),
    .e2 (e2)
  );

`ifdef FIB_CHECK_DOUBLE_RATE_EN
  logic [W-1:0] e_seed;
  assign e_seed = W'(fib_next(64'(a_q), 64'(num), W));
`else
  logic unused_num2;
  assign unused_num2 = ^num2;
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    locked_d  = locked_q;
    err_d     = 1'b0;
    fail_d    = fail_q;
    err_cnt_d = err_cnt_q;
    chk_cnt_d = chk_cnt_q;
    cmp       = 1'b0;
    n_mis     = 2'd0;
    n_chk     = 2'd0;
    ec_sum    = '0;

    if (clr) begin
      state_d   = ST_IDLE;
      a_d       = '0;
      b_d       = '0;
      locked_d  = 1'b0;
      fail_d    = 1'b0;
      err_cnt_d = '0;
      chk_cnt_d = '0;
    end else if (vld) begin
      unique case (state_q)
`ifdef FIB_CHECK_DOUBLE_RATE_EN
        ST_IDLE: begin
          a_d      = num;
          b_d      = num2;
          locked_d = 1'b1;
          state_d  = ST_CHECK;
        end
        ST_SEED: begin
          cmp   = 1'b1;
          n_chk = 2'd1;
          n_mis = {1'b0, num2 != e_seed};
          a_d   = num;
          b_d   = e_seed;
        end
        ST_CHECK, ST_FAIL: begin
          cmp   = 1'b1;
          n_chk = 2'd2;
          n_mis = 2'({1'b0, num != e1}) + 2'({1'b0, num2 != e2});
          a_d   = e1;
          b_d   = e2;
        end
`else
        ST_IDLE: begin
          a_d     = num;
          state_d = ST_SEED;
        end
        ST_SEED: begin
          b_d      = num;
          locked_d = 1'b1;
          state_d  = ST_CHECK;
        end
        ST_CHECK, ST_FAIL: begin
          // Reference advances on the expected value so one bad beat cannot
          // poison every later comparison.
          cmp   = 1'b1;
          n_chk = 2'd1;
          n_mis = {1'b0, num != e1};
          a_d   = b_q;
          b_d   = e1;
        end
`endif
        default: state_d = ST_IDLE;
      endcase

      if (cmp) begin
        chk_cnt_d = chk_cnt_q + 16'(n_chk);
        ec_sum    = {1'b0, err_cnt_q} + (CW+1)'(n_mis);
        err_cnt_d = ec_sum[CW] ? '1 : ec_sum[CW-1:0];
        if (n_mis != 2'd0) begin
          err_d    = 1'b1;
          fail_d   = 1'b1;
          locked_d = 1'b0;
          state_d  = ST_FAIL;
        end else if (state_q == ST_SEED) begin
          locked_d = 1'b1;
          state_d  = ST_CHECK;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      fail_q    <= 1'b0;
      err_cnt_q <= '0;
      chk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      fail_q    <= fail_d;
      err_cnt_q <= err_cnt_d;
      chk_cnt_q <= chk_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign fail      = fail_q;
  assign err_cnt   = err_cnt_q;
  assign chk_cnt   = chk_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fibonacci_checker.sv
// Self-checking bench for fibonacci_checker against a sequence-level reference model.
module tb_fibonacci_checker;
  import fib_pkg::*;

  localparam int     W   = 16;
  localparam int     CW  = 8;
  localparam longint MOD = 64'd1 << W;
  localparam int     EMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, clr, vld;
  logic [W-1:0]  num, num2;
  logic          locked, err, fail;
  logic [CW-1:0] err_cnt;
  logic [15:0]   chk_cnt;
  logic [1:0]    dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the last two reference terms of the sequence plus flags.
  longint ref_q[$];
  bit     m_locked, m_err, m_fail;
  int     m_err_cnt, m_chk_cnt;

  always #5 clk = ~clk;

  fibonacci_checker #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .vld(vld), .num(num), .num2(num2),
    .locked(locked), .err(err), .fail(fail), .err_cnt(err_cnt),
    .chk_cnt(chk_cnt), .dbg_state(dbg_state)
  );

  task automatic model_clear();
    ref_q.delete();
    m_locked = 0; m_err = 0; m_fail = 0; m_err_cnt = 0; m_chk_cnt = 0;
  endtask

  function automatic longint next_term();
    return (ref_q[ref_q.size()-1] + ref_q[ref_q.size()-2]) % MOD;
  endfunction

  task automatic model_step(bit c, bit v, longint n, longint n2);
    longint e;
    int mis, k;
    m_err = 0;
    if (c) begin model_clear(); return; end
    if (!v) return;
    mis = 0;
`ifdef FIB_CHECK_DOUBLE_RATE_EN
    if (ref_q.size() == 0) begin
      ref_q.push_back(n); ref_q.push_back(n2); m_locked = 1; return;
    end
    e = next_term(); if (n != e) mis++; ref_q.push_back(e); void'(ref_q.pop_front());
    e = next_term(); if (n2 != e) mis++; ref_q.push_back(e); void'(ref_q.pop_front());
    k = 2;
`else
    if (ref_q.size() < 2) begin
      ref_q.push_back(n);
      if (ref_q.size() == 2) m_locked = 1;
      return;
    end
    e = next_term(); if (n != e) mis++; ref_q.push_back(e); void'(ref_q.pop_front());
    k = 1;
`endif
    m_chk_cnt = (m_chk_cnt + k) % 65536;
    if (mis > 0) begin
      m_err = 1; m_fail = 1; m_locked = 0;
      m_err_cnt = (m_err_cnt + mis > EMAX) ? EMAX : m_err_cnt + mis;
    end
  endtask

  // One clock of stimulus; inputs return to idle just after the edge.
  task automatic drive(bit c, bit v, logic [W-1:0] n, logic [W-1:0] n2);
    @(negedge clk);
    clr = c; vld = v; num = n; num2 = n2;
    @(posedge clk);
    #1;
    clr = 1'b0; vld = 1'b0;
    model_step(c, v, longint'(n), longint'(n2));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; clr = 1'b0; vld = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b0; clr = 1'b0; vld = 1'b0; num = '0; num2 = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({locked, err, fail, err_cnt, chk_cnt, dbg_state} !== {1'b0, 1'b0, 1'b0, 8'd0, 16'd0, ST_IDLE}) begin
      n_err++;
      $display("FAIL reset: got l%0b e%0b f%0b ec%0d cc%0d st%0d, want all zero/IDLE",
               locked, err, fail, err_cnt, chk_cnt, dbg_state);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

`ifndef FIB_CHECK_DOUBLE_RATE_EN
  task automatic test_good_stream();
    int s[7] = '{1, 1, 2, 3, 5, 8, 13};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, W'(s[i]), '0);
      n_vec++;
      if ({locked, err, fail, err_cnt, chk_cnt} !== {m_locked, m_err, m_fail, CW'(m_err_cnt), 16'(m_chk_cnt)}) begin
        n_err++;
        $display("FAIL good_stream beat%0d: got l%0b e%0b f%0b ec%0d cc%0d, want l%0b e%0b f%0b ec%0d cc%0d",
                 i, locked, err, fail, err_cnt, chk_cnt, m_locked, m_err, m_fail, m_err_cnt, m_chk_cnt);
      end
    end
    n_vec++;
    if ({locked, fail, chk_cnt} !== {1'b1, 1'b0, 16'd5}) begin
      n_err++;
      $display("FAIL good_stream_end: got l%0b f%0b cc%0d, want l1 f0 cc5", locked, fail, chk_cnt);
    end
  endtask

  task automatic test_mismatch();
    int s[5] = '{1, 1, 2, 4, 6};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, W'(s[i]), '0);
      n_vec++;
      if ({locked, err, fail, err_cnt, chk_cnt} !== {m_locked, m_err, m_fail, CW'(m_err_cnt), 16'(m_chk_cnt)}) begin
        n_err++;
        $display("FAIL mismatch beat%0d: got l%0b e%0b f%0b ec%0d cc%0d, want l%0b e%0b f%0b ec%0d cc%0d",
                 i, locked, err, fail, err_cnt, chk_cnt, m_locked, m_err, m_fail, m_err_cnt, m_chk_cnt);
      end
    end
    drive(0, 0, '0, '0);
    n_vec++;
    if ({locked, err, fail, err_cnt, dbg_state} !== {1'b0, 1'b0, 1'b1, 8'd2, ST_FAIL}) begin
      n_err++;
      $display("FAIL mismatch_end: got l%0b e%0b f%0b ec%0d st%0d, want l0 e0 f1 ec2 st3",
               locked, err, fail, err_cnt, dbg_state);
    end
  endtask

  task automatic test_wrap();
    int s[4] = '{28657, 46368, 9489, 55857};
    apply_reset();
    for (int i = 0; i < 4; i++) drive(0, 1, W'(s[i]), '0);
    n_vec++;
    if ({err, fail, err_cnt, chk_cnt} !== {1'b0, 1'b0, 8'd0, 16'd2}) begin
      n_err++;
      $display("FAIL wrap: got e%0b f%0b ec%0d cc%0d, want e0 f0 ec0 cc2", err, fail, err_cnt, chk_cnt);
    end
  endtask

  task automatic test_clr();
    apply_reset();
    drive(0, 1, 16'd1, '0); drive(0, 1, 16'd2, '0); drive(0, 1, 16'd3, '0);
    drive(0, 1, 16'd7, '0);  // deliberate mismatch so fail is set before clr
    drive(1, 1, 16'd99, '0);
    n_vec++;
    if ({locked, err, fail, err_cnt, chk_cnt, dbg_state} !== {1'b0, 1'b0, 1'b0, 8'd0, 16'd0, ST_IDLE}) begin
      n_err++;
      $display("FAIL clr: got l%0b e%0b f%0b ec%0d cc%0d st%0d, want all zero/IDLE",
               locked, err, fail, err_cnt, chk_cnt, dbg_state);
    end
    drive(0, 1, 16'd7, '0); drive(0, 1, 16'd9, '0); drive(0, 1, 16'd16, '0);
    n_vec++;
    if ({locked, err, fail, chk_cnt} !== {1'b1, 1'b0, 1'b0, 16'd1}) begin
      n_err++;
      $display("FAIL clr_reseed: got l%0b e%0b f%0b cc%0d, want l1 e0 f0 cc1", locked, err, fail, chk_cnt);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(0, 1, 16'd2, '0); drive(0, 1, 16'd3, '0); drive(0, 1, 16'd9, '0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({locked, err, fail, err_cnt, chk_cnt} !== {1'b0, 1'b0, 1'b0, 8'd0, 16'd0}) begin
      n_err++;
      $display("FAIL async_reset: got l%0b e%0b f%0b ec%0d cc%0d, want all zero", locked, err, fail, err_cnt, chk_cnt);
    end
    #1 rst = 1'b1;
    model_clear();
    drive(0, 1, 16'd4, '0); drive(0, 1, 16'd6, '0);
    n_vec++;
    if ({locked, chk_cnt} !== {1'b1, 16'd0}) begin
      n_err++;
      $display("FAIL async_reseed: got l%0b cc%0d, want l1 cc0", locked, chk_cnt);
    end
    drive(0, 1, 16'd10, '0);
    n_vec++;
    if ({locked, err, chk_cnt} !== {1'b1, 1'b0, 16'd1}) begin
      n_err++;
      $display("FAIL async_check: got l%0b e%0b cc%0d, want l1 e0 cc1", locked, err, chk_cnt);
    end
  endtask
`else
  task automatic test_double_rate();
    int s[10] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 56};
    apply_reset();
    for (int i = 0; i < 4; i++) drive(0, 1, W'(s[2*i]), W'(s[2*i+1]));
    n_vec++;
    if ({locked, err, fail, chk_cnt} !== {1'b1, 1'b0, 1'b0, 16'd6}) begin
      n_err++;
      $display("FAIL double_rate: got l%0b e%0b f%0b cc%0d, want l1 e0 f0 cc6", locked, err, fail, chk_cnt);
    end
    drive(0, 1, W'(s[8]), W'(s[9]));
    n_vec++;
    if ({err, fail, err_cnt, chk_cnt} !== {1'b1, 1'b1, 8'd1, 16'd8}) begin
      n_err++;
      $display("FAIL double_rate_err: got e%0b f%0b ec%0d cc%0d, want e1 f1 ec1 cc8", err, fail, err_cnt, chk_cnt);
    end
  endtask
`endif

  task automatic test_random();
    longint e1, e2;
    logic [W-1:0] n, n2;
    int r;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 99);
      n  = W'($urandom); n2 = W'($urandom);
      if (ref_q.size() == 2 && r < 85) begin
        e1 = next_term();
        e2 = (ref_q[ref_q.size()-1] + e1) % MOD;
`ifdef FIB_CHECK_DOUBLE_RATE_EN
        n = W'(e1); n2 = W'(e2);
`else
        n = W'(e1); n2 = W'(e2 ^ 64'h5a5a);
`endif
        if (r < 8) n = n ^ W'(1 << $urandom_range(0, W-1));
      end
      if (r >= 97)      drive(1, ($urandom_range(0, 1) == 1), n, n2);
      else if (r >= 85) drive(0, 0, n, n2);
      else              drive(0, 1, n, n2);
      n_vec++;
      if ({locked, err, fail, err_cnt, chk_cnt} !== {m_locked, m_err, m_fail, CW'(m_err_cnt), 16'(m_chk_cnt)}) begin
        n_err++;
        $display("FAIL random cyc%0d: got l%0b e%0b f%0b ec%0d cc%0d, want l%0b e%0b f%0b ec%0d cc%0d",
                 i, locked, err, fail, err_cnt, chk_cnt, m_locked, m_err, m_fail, m_err_cnt, m_chk_cnt);
      end
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    drive(0, 1, '0, '0);
`ifndef FIB_CHECK_DOUBLE_RATE_EN
    drive(0, 1, '0, '0);
`endif
    for (int i = 0; i < 300; i++) drive(0, 1, 16'd1, 16'd1);
    n_vec++;
    if ({fail, err_cnt} !== {1'b1, 8'd255}) begin
      n_err++;
      $display("FAIL saturate: got f%0b ec%0d, want f1 ec255", fail, err_cnt);
    end
  endtask

  task automatic test_chk_wrap();
    int beats;
    apply_reset();
    drive(0, 1, '0, '0);
`ifdef FIB_CHECK_DOUBLE_RATE_EN
    beats = 32768;
`else
    drive(0, 1, '0, '0);
    beats = 65536;
`endif
    for (int i = 0; i < beats; i++) drive(0, 1, '0, '0);
    n_vec++;
    if ({locked, fail, chk_cnt} !== {1'b1, 1'b0, 16'd0}) begin
      n_err++;
      $display("FAIL chk_wrap: got l%0b f%0b cc%0d, want l1 f0 cc0", locked, fail, chk_cnt);
    end
    drive(0, 1, '0, '0);
    n_vec++;
    if (chk_cnt !== 16'(m_chk_cnt) || m_chk_cnt == 0) begin
      n_err++;
      $display("FAIL chk_after_wrap: got cc%0d, want cc%0d", chk_cnt, m_chk_cnt);
    end
  endtask

  initial begin
    test_reset();
`ifndef FIB_CHECK_DOUBLE_RATE_EN
    test_good_stream();
    test_mismatch();
    test_wrap();
    test_clr();
    test_async_reset();
`else
    test_double_rate();
`endif
    test_random();
    test_saturate();
    test_chk_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
